if_id_stage: RTL and testbench

Fetch-side consumer of the hazard controls (PCKeep, IFIDKeep) for the 5-stage MIPS pipeline. The block owns the PC register, next-PC selection (sequential, jump, jump-register, taken branch) and the IF/ID pipeline register. It applies hold/flush codes cycle-accurately and keeps stall/flush event counters for debug. It sits between instruction memory and the ID stage.

---
 rtl/if_id_stage.sv | 104 ++++++++++
 tb/tb_if_id_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Fetch side of the 5-stage MIPS pipeline: PC register, next-PC select and IF/ID register.
// Obeys the hazard unit's PCKeep/IFIDKeep codes and keeps saturating stall/flush counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCKeep,
  input  logic [1:0]       IFIDKeep,
  input  logic [1:0]       Jump,
  input  logic [31:0]      JrTarget,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic [31:0]      IMemData,
  output logic [31:0]      IMemAddr,
  output logic [31:0]      IFID_Instr,
  output logic [31:0]      IFID_PC4,
  output logic             IFID_Valid,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      pc_q;
  logic [31:0]      pc4;
  logic [31:0]      jump_target;
  logic [31:0]      pc_next;
  logic [31:0]      ifid_instr_q;
  logic [31:0]      ifid_pc4_q;
  logic             ifid_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             ifid_flush;
  logic             ifid_hold;

  assign pc4         = pc_q + 32'd4;
  assign jump_target = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};

  // Codes 10 and 11 both flush; only 01 holds.
  assign ifid_flush = IFIDKeep[1];
  assign ifid_hold  = (IFIDKeep == 2'b01);

  // A taken branch in EX is older than any jump sitting in ID, so it wins.
  always_comb begin
    pc_next = pc4;
    if (PCKeep) begin
      pc_next = pc_q;
    end else if (BranchTaken) begin
      pc_next = BranchTarget;
    end else if (Jump == 2'b10) begin
      pc_next = JrTarget;
    end else if (Jump[0]) begin
      pc_next = jump_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr_q <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else if (ifid_flush) begin
      ifid_instr_q <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else if (!ifid_hold) begin
      ifid_instr_q <= IMemData;
      ifid_pc4_q   <= pc4;
      ifid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (PCKeep && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (ifid_flush && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign IMemAddr   = pc_q;
  assign IFID_Instr = ifid_instr_q;
  assign IFID_PC4   = ifid_pc4_q;
  assign IFID_Valid = ifid_valid_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with 4-bit counters so saturation is reachable.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic        PCKeep;
  logic [1:0]  IFIDKeep;
  logic [1:0]  Jump;
  logic [31:0] JrTarget;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] IMemData;
  logic [31:0] IMemAddr;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PC4;
  logic        IFID_Valid;
  logic [3:0]  StallCount;
  logic [3:0]  FlushCount;

  int tests_run = 0;
  int tests_failed = 0;

  if_id_stage #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .PCKeep(PCKeep), .IFIDKeep(IFIDKeep), .Jump(Jump),
    .JrTarget(JrTarget), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .IMemData(IMemData), .IMemAddr(IMemAddr), .IFID_Instr(IFID_Instr),
    .IFID_PC4(IFID_PC4), .IFID_Valid(IFID_Valid), .StallCount(StallCount),
    .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCKeep = 1'b0; IFIDKeep = 2'b00; Jump = 2'b00; JrTarget = 32'd0;
    BranchTaken = 1'b0; BranchTarget = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    IMemData = 32'h2008_0001;
    BranchTaken = 1'b1; BranchTarget = 32'h40;
    step();
    tests_run++;
    if (IMemAddr !== 32'h40) begin tests_failed++; $display("FAIL reset_pre_pc got=%h exp=%h", IMemAddr, 32'h40); end
    reset = 1'b1;
    #1;
    tests_run++;
    if (IMemAddr !== 32'h0 || IFID_Valid !== 1'b0 || IFID_Instr !== 32'h0 || IFID_PC4 !== 32'h0)
      begin tests_failed++; $display("FAIL reset_async got pc=%h instr=%h pc4=%h v=%b exp 0/0/0/0", IMemAddr, IFID_Instr, IFID_PC4, IFID_Valid); end
    tests_run++;
    if (StallCount !== 4'd0 || FlushCount !== 4'd0)
      begin tests_failed++; $display("FAIL reset_counters got s=%0d f=%0d exp 0/0", StallCount, FlushCount); end
    idle_inputs();
    step();
    tests_run++;
    if (IMemAddr !== 32'h0) begin tests_failed++; $display("FAIL reset_held_pc got=%h exp=0", IMemAddr); end
    #3 reset = 1'b0;
    step();
    tests_run++;
    if (IMemAddr !== 32'h4 || IFID_Instr !== 32'h2008_0001 || IFID_PC4 !== 32'h4 || IFID_Valid !== 1'b1)
      begin tests_failed++; $display("FAIL run_edge1 got pc=%h instr=%h pc4=%h v=%b exp 4/20080001/4/1", IMemAddr, IFID_Instr, IFID_PC4, IFID_Valid); end
    step();
    tests_run++;
    if (IMemAddr !== 32'h8 || IFID_PC4 !== 32'h8)
      begin tests_failed++; $display("FAIL run_edge2 got pc=%h pc4=%h exp 8/8", IMemAddr, IFID_PC4); end
  endtask

  task automatic test_stall();
    IMemData = 32'h1111_0001;
    BranchTaken = 1'b1; BranchTarget = 32'h10;
    step();
    idle_inputs();
    IMemData = 32'h2222_0002;
    PCKeep = 1'b1; IFIDKeep = 2'b01;
    step();
    tests_run++;
    if (IMemAddr !== 32'h10) begin tests_failed++; $display("FAIL stall_pc got=%h exp=10", IMemAddr); end
    tests_run++;
    if (IFID_Instr !== 32'h1111_0001 || IFID_PC4 !== 32'hC || IFID_Valid !== 1'b1)
      begin tests_failed++; $display("FAIL stall_ifid_hold got instr=%h pc4=%h v=%b exp 11110001/c/1", IFID_Instr, IFID_PC4, IFID_Valid); end
    tests_run++;
    if (StallCount !== 4'd1) begin tests_failed++; $display("FAIL stall_count got=%0d exp=1", StallCount); end
    idle_inputs();
    step();
    tests_run++;
    if (IMemAddr !== 32'h14 || IFID_Instr !== 32'h2222_0002 || IFID_PC4 !== 32'h14)
      begin tests_failed++; $display("FAIL stall_resume got pc=%h instr=%h pc4=%h exp 14/22220002/14", IMemAddr, IFID_Instr, IFID_PC4); end
  endtask

  task automatic test_jump();
    BranchTaken = 1'b1; BranchTarget = 32'h4;
    step();
    idle_inputs();
    IMemData = 32'h0800_0040;
    step();
    tests_run++;
    if (IFID_Instr !== 32'h0800_0040 || IFID_PC4 !== 32'h8)
      begin tests_failed++; $display("FAIL jump_setup got instr=%h pc4=%h exp 08000040/8", IFID_Instr, IFID_PC4); end
    Jump = 2'b01; IFIDKeep = 2'b10;
    step();
    tests_run++;
    if (IMemAddr !== 32'h100) begin tests_failed++; $display("FAIL jump_pc got=%h exp=100", IMemAddr); end
    tests_run++;
    if (IFID_Instr !== 32'h0 || IFID_PC4 !== 32'h0 || IFID_Valid !== 1'b0)
      begin tests_failed++; $display("FAIL jump_bubble got instr=%h pc4=%h v=%b exp 0/0/0", IFID_Instr, IFID_PC4, IFID_Valid); end
    tests_run++;
    if (FlushCount !== 4'd1) begin tests_failed++; $display("FAIL jump_flush_count got=%0d exp=1", FlushCount); end
    idle_inputs();
  endtask

  task automatic test_jr_branch();
    IMemData = 32'h0800_0050;
    Jump = 2'b10; JrTarget = 32'h200;
    BranchTaken = 1'b1; BranchTarget = 32'h80;
    step();
    tests_run++;
    if (IMemAddr !== 32'h80) begin tests_failed++; $display("FAIL jr_vs_branch got=%h exp=80", IMemAddr); end
    // IF/ID now holds 0x0800_0050 with PC4 0x104; code 11 behaves as j.
    idle_inputs();
    Jump = 2'b11;
    step();
    tests_run++;
    if (IMemAddr !== 32'h140) begin tests_failed++; $display("FAIL jump11_pc got=%h exp=140", IMemAddr); end
    idle_inputs();
    Jump = 2'b10; JrTarget = 32'h200;
    step();
    tests_run++;
    if (IMemAddr !== 32'h200) begin tests_failed++; $display("FAIL jr_pc got=%h exp=200", IMemAddr); end
    idle_inputs();
  endtask

  task automatic test_stall_branch();
    PCKeep = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h300;
    Jump = 2'b10; JrTarget = 32'h400; IFIDKeep = 2'b11;
    step();
    tests_run++;
    if (IMemAddr !== 32'h200) begin tests_failed++; $display("FAIL stall_beats_branch got=%h exp=200", IMemAddr); end
    tests_run++;
    if (IFID_Valid !== 1'b0 || IFID_Instr !== 32'h0)
      begin tests_failed++; $display("FAIL flush11_bubble got instr=%h v=%b exp 0/0", IFID_Instr, IFID_Valid); end
    tests_run++;
    if (StallCount !== 4'd2 || FlushCount !== 4'd2)
      begin tests_failed++; $display("FAIL stall_branch_counts got s=%0d f=%0d exp 2/2", StallCount, FlushCount); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    IMemData = 32'hDEAD_0003;
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    step();
    tests_run++;
    if (IMemAddr !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc got=%h exp=0", IMemAddr); end
    tests_run++;
    if (IFID_PC4 !== 32'h0 || IFID_Valid !== 1'b1 || IFID_Instr !== 32'hDEAD_0003)
      begin tests_failed++; $display("FAIL wrap_pc4 got pc4=%h v=%b instr=%h exp 0/1/dead0003", IFID_PC4, IFID_Valid, IFID_Instr); end
  endtask

  task automatic test_saturation();
    PCKeep = 1'b1; IFIDKeep = 2'b10;
    for (int i = 0; i < 12; i++) step();
    tests_run++;
    if (StallCount !== 4'd14) begin tests_failed++; $display("FAIL stall_count_pre_sat got=%0d exp=14", StallCount); end
    for (int i = 0; i < 8; i++) step();
    tests_run++;
    if (StallCount !== 4'hF) begin tests_failed++; $display("FAIL stall_saturate got=%0d exp=15", StallCount); end
    tests_run++;
    if (FlushCount !== 4'hF) begin tests_failed++; $display("FAIL flush_saturate got=%0d exp=15", FlushCount); end
    tests_run++;
    if (IMemAddr !== 32'h0) begin tests_failed++; $display("FAIL sat_pc_held got=%h exp=0", IMemAddr); end
    // Reset in the middle of a stall/flush clears everything at once.
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (StallCount !== 4'd0 || FlushCount !== 4'd0 || IFID_Valid !== 1'b0)
      begin tests_failed++; $display("FAIL reset_mid_stall got s=%0d f=%0d v=%b exp 0/0/0", StallCount, FlushCount, IFID_Valid); end
    idle_inputs();
    #2 reset = 1'b0;
    step();
    tests_run++;
    if (IMemAddr !== 32'h4 || IFID_Valid !== 1'b1 || StallCount !== 4'd0)
      begin tests_failed++; $display("FAIL post_reset_run got pc=%h v=%b s=%0d exp 4/1/0", IMemAddr, IFID_Valid, StallCount); end
  endtask

  initial begin
    reset = 1'b1;
    IMemData = 32'd0;
    idle_inputs();
    #12 reset = 1'b0;
    test_reset();
    test_stall();
    test_jump();
    test_jr_branch();
    test_stall_branch();
    test_wrap();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
